spi_controller: RTL



---
 rtl/spi_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/spi_controller.sv
// spi_controller: SPI initiator, mode 0, MSB first, one full-duplex word of
// DATA_BITS per transaction. It is the controller end of the rapcore SPI link.
//
// Ports
//   wb_clk_i     system clock
//   wb_rstn_i    synchronous active-low reset
//   start_valid  request a transfer; tx_data is captured on acceptance
//   start_ready  request can be accepted this cycle
//   tx_data      word to shift out
//   rx_data      word shifted in; updated with rx_valid, then held
//   rx_valid     one-cycle pulse when rx_data is updated
//   busy         transfer in progress (CS low or inter-frame gap)
//   SCK/CS/COPI  serial clock (idle low), chip select (active low), data out
//   CIPO         serial data in, sampled on the edge that raises SCK
//   last         (SPI_CONTROLLER_BURST_EN only) 0 keeps CS low after the word
//
// Build option: define SPI_CONTROLLER_BURST_EN to add the `last` port and
// multi-word CS frames.
//
// state | meaning
// IDLE  | CS high, waiting for a request
// SETUP | CS low, SCK low, COPI shows the MSB
// HIGH  | SCK high; CIPO sampled on entry
// LOW   | SCK low; COPI advanced on entry (except after the final bit)
// HOLD  | SCK low, CS low, COPI holds last bit; rx published on exit
// GAP   | CS high, minimum deselect time before the next frame
// WAIT  | burst only: word done, CS held low, ready for the next word
module spi_controller #(
  parameter int DATA_BITS = 64,
  parameter int CLK_DIV   = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rstn_i,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
`ifdef SPI_CONTROLLER_BURST_EN
  input  logic                 last,
`endif
  input  logic                 CIPO
);

  localparam int               BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
`ifdef SPI_CONTROLLER_BURST_EN
    , S_WAIT
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           half_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 phase_done;
  logic                 last_bit;
  logic                 accept;
  logic                 word_done;
  logic                 timed;
`ifdef SPI_CONTROLLER_BURST_EN
  logic                 last_q;
`endif

  assign phase_done = (half_cnt == DIV_LAST);
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign timed      = (state == S_SETUP) || (state == S_HIGH) || (state == S_LOW) ||
                      (state == S_HOLD)  || (state == S_GAP);

  assign SCK  = (state == S_HIGH);
  assign CS   = (state == S_IDLE) || (state == S_GAP);
  assign busy = (state != S_IDLE);
  assign COPI = !CS && tx_shift[DATA_BITS-1];
`ifdef SPI_CONTROLLER_BURST_EN
  assign start_ready = (state == S_IDLE) || (state == S_WAIT);
`else
  assign start_ready = (state == S_IDLE);
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    word_done = 1'b0;
    case (state)
      S_IDLE: if (start_valid) begin
        accept    = 1'b1;
        state_nxt = S_SETUP;
      end
      S_SETUP: if (phase_done) state_nxt = S_HIGH;
      S_HIGH:  if (phase_done) state_nxt = S_LOW;
      S_LOW: if (phase_done) begin
        if (!last_bit) state_nxt = S_HIGH;
`ifdef SPI_CONTROLLER_BURST_EN
        else if (!last_q) begin
          // mid-burst word: publish now and keep CS asserted
          state_nxt = S_WAIT;
          word_done = 1'b1;
        end
`endif
        else state_nxt = S_HOLD;
      end
      S_HOLD: if (phase_done) begin
        state_nxt = S_GAP;
        word_done = 1'b1;
      end
      S_GAP: if (phase_done) state_nxt = S_IDLE;
`ifdef SPI_CONTROLLER_BURST_EN
      S_WAIT: if (start_valid) begin
        accept    = 1'b1;
        state_nxt = S_HIGH;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
`ifdef SPI_CONTROLLER_BURST_EN
      last_q   <= 1'b1;
`endif
    end else begin
      rx_valid <= word_done;
      if (state_nxt != state) half_cnt <= '0;
      else if (timed)         half_cnt <= half_cnt + 8'd1;
      // the final bit stays on COPI through the closing LOW and HOLD phases
      if (accept)
        tx_shift <= tx_data;
      else if (state == S_HIGH && phase_done && !last_bit)
        tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
      if (state_nxt == S_HIGH && state != S_HIGH)
        rx_shift <= {rx_shift[DATA_BITS-2:0], CIPO};
      if (state == S_LOW && phase_done)
        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      if (word_done) rx_data <= rx_shift;
`ifdef SPI_CONTROLLER_BURST_EN
      if (accept) last_q <= last;
`endif
    end
  end

endmodule
